uart_tx_framer: RTL
===================

# uart_tx_framer

Parametrised UART transmit framer, the next-generation serial transmit controller for the 50 MHz domain. It accepts parallel words through a small write FIFO and serialises each one LSB-first as a complete asynchronous frame. Data width, bit period, parity mode and stop-bit count are configurable. It adds buffering, back-to-back framing, parity, a completion pulse and overflow detection over the single-word transmitter.

## Interface
- DATA_BITS, 8 — data bits per frame, legal 5..9.
- CLKS_PER_BIT, 434 — CLK_50M cycles per serial bit (115200 baud), legal ≥ 2.
- PARITY, 0 — 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1 — 1 or 2.
- FIFO_DEPTH, 4 — write FIFO entries, power of two, ≥ 2.

- CLK_50M  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_en  in  1  per-cycle write strobe; one word is written per cycle it is high.
- Din  in  DATA_BITS  word to transmit, sampled when send_en is high.
- Dout  out  1  serial line, idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- full  out  1  FIFO holds FIFO_DEPTH words.
- tx_done  out  1  one-cycle pulse at the end of each frame.
- overflow  out  1  sticky; set by a write attempted while full.

## Operation
- Reset values: Dout=1, busy=0, full=0, tx_done=0, overflow=0. Reset also empties the FIFO, puts the FSM in IDLE and clears the baud counter and shift register.
- Write acceptance:
  - A write is accepted iff send_en=1 and full=0, evaluated before the edge.
  - A write while full is dropped and sets overflow, even if the FSM pops in the same cycle.
  - Simultaneous write and pop is legal when not full; the count stays unchanged.
- FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE or START.
- IDLE: Dout=1. If the FIFO is non-empty, pop the head word into the shift register, compute parity, and go to START.
- START: Dout=0 for one bit period.
- DATA: shift out DATA_BITS bits LSB-first, one bit period each. The bit index runs 0..DATA_BITS-1.
- PARITY: one bit period.
  - Even mode: the bit is the XOR of the data bits.
  - Odd mode: the bit is the inverted XOR.
- STOP: Dout=1 for STOP_BITS bit periods. On the final cycle of the last stop bit, assert tx_done. Then:
  - FIFO non-empty: pop and go directly to START, with no idle gap.
  - FIFO empty: go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Width is clog2(CLKS_PER_BIT).
  - A bit ends on the cycle the counter reaches CLKS_PER_BIT-1.
- busy = (FIFO count ≠ 0) or (state ≠ IDLE). It is combinational from registered state.
- full is registered and consistent with the FIFO count after every edge.
- Reset mid-frame: Dout returns to 1 immediately (asynchronously). The frame is abandoned, the FIFO is flushed, and no tx_done is issued.

## Timing
- Dout is registered.
- Latency, idle block with empty FIFO: write accepted at edge k → pop and Dout=0 at edge k+1, so the start bit begins one cycle after the write.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- tx_done:
  - Asserted for exactly one cycle: the last cycle of the final stop bit.
  - With a queued word, START begins on the next edge. Dout goes 1→0 with no extra high cycles.
- busy:
  - Rises at the edge after an accepted write.
  - Falls at the edge that returns the FSM to IDLE with the FIFO empty.
- Throughput: continuous frames with no gap while the FIFO stays non-empty.

## Test plan
- Parameters CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1. Release reset, then pulse send_en for 1 cycle with Din=8'hAC → Dout holds each bit for 4 cycles:
  - Dout sequence: 0, 0,0,1,1,0,1,0,1, 1 (start, data LSB-first, stop).
  - Total 40 cycles; tx_done pulses once; busy then falls.
- PARITY=1 with Din=8'hAC → parity bit 0. PARITY=2 with Din=8'hAC → parity bit 1. Frame length is 44 cycles.
- STOP_BITS=2, Din=8'h01 → stop high for 8 cycles before the next start.
- FIFO_DEPTH=4, send_en held high for 25 cycles with Din stepping 1..25 →
  - Words 1–5 are accepted (the first is popped at once) and transmitted back-to-back with no idle gap.
  - Words 6–25 are dropped.
  - overflow=1 and full=1 during the burst; 5 tx_done pulses.
- Assert reset mid-DATA of the second queued frame → Dout=1, busy=0, overflow=0 immediately; no further frames or tx_done.
- With a write coinciding with the STOP-final-cycle pop and FIFO count 1 → count stays 1, no overflow, next frame starts on the next edge.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: write FIFO feeding an LSB-first serialiser
// with optional parity, one or two stop bits and back-to-back frames.
`timescale 1ns/1ps
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK_50M,
  input  logic                 reset,
  input  logic                 send_en,
  input  logic [DATA_BITS-1:0] Din,
  output logic                 Dout,
  output logic                 busy,
  output logic                 full,
  output logic                 tx_done,
  output logic                 overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 dout_q, dout_d;
  logic                 ovf_q, ovf_d;
  logic                 full_q, full_d;
  logic [AW:0]          fcnt_q, fcnt_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic                 wr_acc;
  logic                 pop;
  logic                 done;
  logic                 bit_end;
  logic                 nonempty;
  logic [DATA_BITS-1:0] head;

  assign wr_acc   = send_en & ~full_q;
  assign nonempty = (fcnt_q != '0);
  assign head     = mem[rptr_q];
  assign bit_end  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ ODD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            done  = 1'b1;
            idx_d = '0;
            // Queued word goes straight into START: no idle gap
            if (nonempty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ ODD;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    dout_d = 1'b1;
    unique case (state_d)
      S_IDLE:  dout_d = 1'b1;
      S_START: dout_d = 1'b0;
      S_DATA:  dout_d = shift_d[0];
      S_PAR:   dout_d = par_d;
      S_STOP:  dout_d = 1'b1;
      default: dout_d = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d = wr_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    fcnt_d = fcnt_q + {{AW{1'b0}}, wr_acc}
                    - {{AW{1'b0}}, pop};
    full_d = (fcnt_d == DEPTH);
    ovf_d  = ovf_q | (send_en & full_q);
  end

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      fcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      fcnt_q  <= fcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (wr_acc) mem[wptr_q] <= Din;
  end

  assign Dout     = dout_q;
  assign busy     = nonempty | (state_q != S_IDLE);
  assign full     = full_q;
  assign tx_done  = done;
  assign overflow = ovf_q;

endmodule
